// File: rtl/cal_acc_pkg.sv
// cal_acc_pkg: shared widths, state encoding and sign extension for the calibration accumulator.
package cal_acc_pkg;
    localparam int DW = 24;
    localparam int AW = 9;
    localparam int SW = 42;

    typedef enum logic [1:0] {IDLE, ACCUM, FLUSH} state_t;

    function automatic logic [SW-1:0] sext(input logic [DW-1:0] d);
        return {{(SW-DW){d[DW-1]}}, d};
    endfunction
endpackage

// File: rtl/cal_acc_fwd.sv
// cal_acc_fwd: recent (valid, bin, sum) history with newest-first match for read-after-write forwarding.
module cal_acc_fwd
    import cal_acc_pkg::*;
#(
    parameter int DEPTH = 3
) (
    input  logic          CLK,
    input  logic          RESETN,
    input  logic          push_valid,
    input  logic [AW-1:0] push_bin,
    input  logic [SW-1:0] push_sum,
    input  logic [AW-1:0] look_bin,
    output logic          hit,
    output logic [SW-1:0] fwd_sum
);
    logic [DEPTH-1:0]         hv;
    logic [DEPTH-1:0][AW-1:0] hb;
    logic [DEPTH-1:0][SW-1:0] hs;

    // Index 0 is the newest entry; idle cycles shift in invalid entries so age is in cycles.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            hv <= '0;
            hb <= '0;
            hs <= '0;
        end else begin
            hv <= {hv[DEPTH-2:0], push_valid};
            hb <= {hb[DEPTH-2:0], push_bin};
            hs <= {hs[DEPTH-2:0], push_sum};
        end
    end

    always_comb begin
        hit = 1'b0;
        fwd_sum = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (hv[i] && hb[i] == look_bin) begin
                hit = 1'b1;
                fwd_sum = hs[i];
            end
        end
    end
endmodule

// File: rtl/cal_bin_accumulator.sv
// cal_bin_accumulator: sums 2^navg_log2 spectra per bin by read-modify-write on the calibration SRAM.
module cal_bin_accumulator
    import cal_acc_pkg::*;
#(
    parameter int RD_LAT        = 2,
    parameter int NAVG_MAX_LOG2 = 15
) (
    input  logic          CLK,
    input  logic          RESETN,
    input  logic          start,
    input  logic [3:0]    navg_log2,
    input  logic          in_valid,
    input  logic [AW-1:0] in_bin,
    input  logic [DW-1:0] in_data,
    input  logic          in_last,
    output logic          busy,
    output logic          done,
    output logic          drop_err,
    output logic          out_valid,
    output logic [AW-1:0] out_bin,
    output logic [SW-1:0] out_data,
    output logic [AW-1:0] ram_r_addr,
    input  logic [SW-1:0] ram_r_data,
    output logic [AW-1:0] ram_w_addr,
    output logic [SW-1:0] ram_w_data,
    output logic          ram_w_en
);
    localparam int L  = RD_LAT - 1;
    localparam int CW = NAVG_MAX_LOG2;
    localparam int FW = $clog2(RD_LAT + 2);

    if (SW < DW + NAVG_MAX_LOG2 + 1) begin : g_width_check
        $error("SW too narrow for DW + NAVG_MAX_LOG2 + 1");
    end

    state_t                    state, state_d;
    logic [3:0]                n;
    logic [CW-1:0]             spec_cnt;
    logic [FW-1:0]             fcnt;
    logic                      accept, start_ok, last_spec, hit;
    logic [RD_LAT-1:0]         pv, pf, pl;
    logic [RD_LAT-1:0][AW-1:0] pb;
    logic [RD_LAT-1:0][DW-1:0] pd;
    logic [SW-1:0]             fwd_sum, sum, res_sum;
    logic [AW-1:0]             res_bin;

    assign accept     = in_valid && state == ACCUM;
    assign start_ok   = start && state == IDLE;
    assign last_spec  = {1'b0, spec_cnt} == ((CW+1)'(1) << n) - 1'b1;
    assign busy       = state != IDLE;
    assign ram_r_addr = in_bin;
    assign ram_w_addr = res_bin;
    assign ram_w_data = res_sum;
    assign out_bin    = res_bin;
    assign out_data   = res_sum;
    // The first spectrum ignores SRAM contents and history; stale data from earlier runs never leaks in.
    assign sum = (pf[L] ? '0 : hit ? fwd_sum : ram_r_data) + sext(pd[L]);

    always_comb begin
        state_d = state;
        if (start_ok) state_d = ACCUM;
        if (accept && in_last && last_spec) state_d = FLUSH;
        if (state == FLUSH && fcnt == FW'(RD_LAT)) state_d = IDLE;
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state     <= IDLE;
            n         <= '0;
            spec_cnt  <= '0;
            fcnt      <= '0;
            done      <= 1'b0;
            drop_err  <= 1'b0;
            pv        <= '0;
            pf        <= '0;
            pl        <= '0;
            pb        <= '0;
            pd        <= '0;
            ram_w_en  <= 1'b0;
            out_valid <= 1'b0;
            res_bin   <= '0;
            res_sum   <= '0;
        end else begin
            state    <= state_d;
            fcnt     <= state == FLUSH ? fcnt + 1'b1 : '0;
            done     <= state == FLUSH && fcnt == FW'(RD_LAT);
            drop_err <= (drop_err && !start_ok) || (in_valid && state != ACCUM);
            if (start_ok) begin
                n        <= ({1'b0, navg_log2} > 5'(NAVG_MAX_LOG2)) ? 4'(NAVG_MAX_LOG2) : navg_log2;
                spec_cnt <= '0;
            end else if (accept && in_last && !last_spec) begin
                spec_cnt <= spec_cnt + 1'b1;
            end
            pv[0] <= accept;
            pf[0] <= spec_cnt == '0;
            pl[0] <= last_spec;
            pb[0] <= in_bin;
            pd[0] <= in_data;
            for (int i = 1; i < RD_LAT; i++) begin
                pv[i] <= pv[i-1];
                pf[i] <= pf[i-1];
                pl[i] <= pl[i-1];
                pb[i] <= pb[i-1];
                pd[i] <= pd[i-1];
            end
            ram_w_en  <= pv[L] && !pl[L];
            out_valid <= pv[L] && pl[L];
            if (pv[L]) begin
                res_bin <= pb[L];
                res_sum <= sum;
            end
        end
    end

    cal_acc_fwd #(.DEPTH(RD_LAT + 1)) u_fwd (
        .CLK       (CLK),
        .RESETN    (RESETN),
        .push_valid(pv[L]),
        .push_bin  (pb[L]),
        .push_sum  (sum),
        .look_bin  (pb[L]),
        .hit       (hit),
        .fwd_sum   (fwd_sum)
    );
endmodule

// File: tb/tb_cal_bin_accumulator.sv
// tb_cal_bin_accumulator: directed scenarios against a two-port SRAM model with a scoreboard monitor.
module tb_cal_bin_accumulator;
    import cal_acc_pkg::*;

    logic          CLK = 1'b0, RESETN = 1'b0, start = 1'b0, in_valid = 1'b0, in_last = 1'b0;
    logic [3:0]    navg_log2 = '0;
    logic [AW-1:0] in_bin = '0;
    logic [DW-1:0] in_data = '0;
    logic          busy, done, drop_err, out_valid, ram_w_en;
    logic [AW-1:0] out_bin, ram_r_addr, ram_w_addr;
    logic [SW-1:0] out_data, ram_r_data, ram_w_data;
    logic [SW-1:0] mem [512];
    logic [SW-1:0] r1, r2;

    int checks = 0, errors = 0, cyc = 0, wr_cnt = 0, done_cnt = 0, out_cyc = 0, done_cyc = 0;

    typedef struct {
        logic [AW-1:0] bin;
        longint        data;
    } exp_t;
    exp_t sb[$];

    cal_bin_accumulator dut (
        .CLK       (CLK),
        .RESETN    (RESETN),
        .start     (start),
        .navg_log2 (navg_log2),
        .in_valid  (in_valid),
        .in_bin    (in_bin),
        .in_data   (in_data),
        .in_last   (in_last),
        .busy      (busy),
        .done      (done),
        .drop_err  (drop_err),
        .out_valid (out_valid),
        .out_bin   (out_bin),
        .out_data  (out_data),
        .ram_r_addr(ram_r_addr),
        .ram_r_data(ram_r_data),
        .ram_w_addr(ram_w_addr),
        .ram_w_data(ram_w_data),
        .ram_w_en  (ram_w_en)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (ram_w_en) mem[ram_w_addr] <= ram_w_data;
        r1 <= mem[ram_r_addr];
        r2 <= r1;
    end
    assign ram_r_data = r2;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge CLK) begin : monitor
        exp_t e;
        if (RESETN) begin
            if (ram_w_en) wr_cnt++;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (out_valid) begin
                out_cyc = cyc;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: got bin %0d data %0d with nothing expected", out_bin, $signed(out_data));
                end else begin
                    e = sb.pop_front();
                    check("out_bin", longint'(out_bin), e.data == e.data ? longint'(e.bin) : 0);
                    check("out_data", longint'($signed(out_data)), e.data);
                end
            end
        end
    end

    task automatic beat(input logic v, input int bin, input longint data, input logic last);
        in_valid = v;
        in_bin   = AW'(bin);
        in_data  = DW'(data);
        in_last  = last;
        @(posedge CLK); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic do_start(input int n);
        start     = 1'b1;
        navg_log2 = 4'(n);
        @(posedge CLK); #1;
        start = 1'b0;
    endtask

    task automatic finish_scn(input string name, input int d0);
        int k = 0;
        while (done_cnt == d0 && k < 40000) begin
            @(posedge CLK);
            k++;
        end
        repeat (3) @(posedge CLK);
        #1;
        check({name, "_done"}, done_cnt - d0, 1);
        check({name, "_sb_left"}, sb.size(), 0);
        check({name, "_busy"}, longint'(busy), 0);
        sb.delete();
    endtask

    task automatic scen2();
        int d0 = done_cnt;
        int w0 = wr_cnt;
        do_start(2);
        for (int s = 0; s < 4; s++) begin
            for (int b = 0; b < 512; b++) begin
                if (s == 3) sb.push_back('{AW'(b), longint'(4 * b)});
                beat(1'b1, b, b, b == 511);
            end
        end
        finish_scn("s2", d0);
        check("s2_writes", wr_cnt - w0, 1536);
    endtask

    task automatic scen_len(input int len);
        int d0 = done_cnt;
        longint acc[4] = '{default: 0};
        do_start(2);
        for (int s = 0; s < 4; s++) begin
            for (int j = 0; j < len; j++) begin
                longint v;
                v = (s + 1) * (j * 7 - 5) - 100 * s;
                acc[j] += v;
                if (s == 3) sb.push_back('{AW'(10 + j), acc[j]});
                beat(1'b1, 10 + j, v, j == len - 1);
            end
        end
        finish_scn($sformatf("len%0d", len), d0);
    endtask

    task automatic scen_bin7(input bit gap);
        int d0 = done_cnt;
        do_start(3);
        sb.push_back('{AW'(7), 64'sd8});
        repeat (8) begin
            beat(1'b1, 7, 1, 1'b1);
            if (gap) beat(1'b0, 0, 0, 1'b0);
        end
        finish_scn(gap ? "bin7_gap" : "bin7", d0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish, expected finish within 100000 cycles");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, w0, t0;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_busy", longint'(busy), 0);
        check("rst_done", longint'(done), 0);
        check("rst_drop_err", longint'(drop_err), 0);
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_ram_w_en", longint'(ram_w_en), 0);
        check("rst_out_data", longint'(out_data), 0);
        check("rst_ram_w_addr", longint'(ram_w_addr), 0);
        RESETN = 1'b1;
        @(posedge CLK); #1;

        // protocol: drops in IDLE and FLUSH, ignored start in ACCUM
        d0 = done_cnt;
        beat(1'b1, 20, 99, 1'b0);
        check("drop_idle", longint'(drop_err), 1);
        do_start(1);
        check("drop_clr", longint'(drop_err), 0);
        check("busy_accum", longint'(busy), 1);
        beat(1'b1, 20, 5, 1'b0);
        beat(1'b1, 21, 6, 1'b1);
        start = 1'b1;
        navg_log2 = 4'd0;
        beat(1'b1, 20, 7, 1'b0);
        start = 1'b0;
        check("start_in_accum", longint'(drop_err), 0);
        sb.push_back('{AW'(20), 64'sd12});
        sb.push_back('{AW'(21), 64'sd14});
        beat(1'b1, 21, 8, 1'b1);
        beat(1'b1, 20, 1000, 1'b1);
        check("drop_flush", longint'(drop_err), 1);
        finish_scn("proto", d0);

        // single beat, single spectrum: latency and no writes
        d0 = done_cnt;
        w0 = wr_cnt;
        do_start(0);
        check("s1_drop_clr", longint'(drop_err), 0);
        sb.push_back('{AW'(5), -64'sd100});
        t0 = cyc;
        beat(1'b1, 5, -100, 1'b1);
        finish_scn("s1", d0);
        check("s1_out_lat", out_cyc - t0, 3);
        check("s1_done_lat", done_cyc - t0, 4);
        check("s1_writes", wr_cnt - w0, 0);

        for (int len = 1; len <= 4; len++) scen_len(len);
        scen_bin7(1'b0);
        scen_bin7(1'b1);
        scen2();

        // abort mid-ACCUM, then a clean rerun
        do_start(2);
        for (int b = 0; b < 300; b++) beat(1'b1, b, b, 1'b0);
        RESETN = 1'b0;
        #1;
        check("abort_busy", longint'(busy), 0);
        check("abort_out_valid", longint'(out_valid), 0);
        check("abort_w_en", longint'(ram_w_en), 0);
        d0 = done_cnt;
        w0 = wr_cnt;
        @(posedge CLK); #1;
        RESETN = 1'b1;
        repeat (6) @(posedge CLK);
        #1;
        check("abort_writes", wr_cnt - w0, 0);
        check("abort_done", done_cnt - d0, 0);
        scen2();

        // extreme: 2^15 beats of the most negative sample
        d0 = done_cnt;
        do_start(15);
        sb.push_back('{AW'(511), -64'sd274877906944});
        repeat (32768) beat(1'b1, 511, -8388608, 1'b1);
        finish_scn("extreme", d0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cal_bin_accumulator.md
Name: cal_bin_accumulator

Overview:
Read-modify-write spectral accumulator sitting directly upstream of the 512x42 two-port calibration SRAM in the CAL_PROCESS path. Takes a stream of signed per-bin samples and sums 2^navg_log2 consecutive spectra per bin in the SRAM, using the SRAM's write and read ports. On the final spectrum it emits the completed per-bin sums downstream. Includes forwarding so back-to-back hits on the same bin are summed correctly despite the SRAM's pipelined read latency.

Parameters:
DW, 24, input sample width (signed)
AW, 9, bin address width (512 bins)
SW, 42, accumulator / SRAM word width
RD_LAT, 2, SRAM read latency in cycles (registered output)
NAVG_MAX_LOG2, 15, largest legal navg_log2. SW >= DW+NAVG_MAX_LOG2+1 is enforced by an elaboration check.

Ports:
CLK  in  1  clock (single clock domain, shared with SRAM)
RESETN  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; arms a new accumulation (honoured only in IDLE)
navg_log2  in  4  spectra to sum = 2^navg_log2; sampled on accepted start
in_valid  in  1  sample beat valid (no backpressure)
in_bin  in  AW  bin index of the beat
in_data  in  DW  signed sample
in_last  in  1  beat is last bin of current spectrum
busy  out  1  high in ACCUM and FLUSH
done  out  1  one-cycle pulse when the final result has been emitted
drop_err  out  1  sticky: in_valid seen while not in ACCUM; cleared by accepted start
out_valid  out  1  completed-sum beat
out_bin  out  AW  bin of out_data
out_data  out  SW  signed accumulated sum
ram_r_addr  out  AW  to SRAM R_ADDR
ram_r_data  in  SW  from SRAM R_DATA
ram_w_addr  out  AW  to SRAM W_ADDR
ram_w_data  out  SW  to SRAM W_DATA
ram_w_en  out  1  to SRAM W_EN

Behaviour:
- Reset: state IDLE; busy, done, drop_err, out_valid, ram_w_en = 0; all address/data outputs = 0; forwarding history invalid. SRAM contents are not cleared, because the first spectrum overwrites them.
- States:
  - IDLE -> ACCUM on start. This latches navg_log2, spec_cnt=0, clears drop_err.
  - ACCUM -> FLUSH on an accepted beat with in_last=1 and spec_cnt == 2^n-1. Otherwise in_last increments spec_cnt.
  - FLUSH lasts RD_LAT+1 cycles, then done=1 for one cycle and the block returns to IDLE.
- Beats are accepted only in ACCUM. Any in_valid in IDLE or FLUSH is dropped and sets drop_err. A start outside IDLE is ignored.
- Pipeline for a beat accepted at cycle t:
  - ram_r_addr = in_bin combinationally at t.
  - ram_r_data is valid at t+RD_LAT.
  - The sum is registered and presented at t+RD_LAT+1 (t+3 by default) on ram_w_* or out_*.
- Operand selection:
  - First spectrum (spec_cnt==0): old value = 0, so the write is sign-extended in_data.
  - Middle spectra: old value = ram_r_data, or the forwarded value.
  - Last spectrum: compute the same sum, drive out_valid/out_bin/out_data, keep ram_w_en=0.
- Forwarding: the read issued at t does not see writes issued at t..t+RD_LAT, i.e. the RD_LAT+1 previous beats.
  - Keep a history of the last RD_LAT+1 beats as (valid, bin, sum).
  - If the current beat's bin matches, use the most recent matching sum instead of ram_r_data.
  - The history holds only accepted beats, in order. Gaps (in_valid=0) age the history.
- Arithmetic: sum = old + sign_extend(in_data), signed two's complement, SW bits. Overflow cannot occur within the legal range, so there is no saturation.
- navg_log2 > NAVG_MAX_LOG2 is clamped to NAVG_MAX_LOG2.
- Throughput: one beat per cycle sustained. The spectrum length is set by in_last, so short spectra are legal.
- RESETN asserted mid-operation aborts immediately, with no done and no further writes. The next start yields a correct result.

Decomposition:
- Package cal_acc_pkg holds: width constants (DW, AW, SW), the state enum (IDLE/ACCUM/FLUSH), and the sign-extend function.
- One sub-module, cal_acc_fwd, holds the RD_LAT+1 deep (valid, bin, sum) history plus the priority match. It outputs hit and fwd_sum.

Test Plan:
- navg_log2=0, start, single beat bin=5, data=-100, in_last=1 -> out_valid at t+3 with out_bin=5, out_data=-100 (42-bit sign-extended). No ram_w_en ever. done at t+4.
- navg_log2=2, four 512-bin spectra with data=bin back-to-back -> 512 out beats with out_data=4*bin in bin order. done once. 1536 SRAM writes.
- Forwarding: navg_log2=3, 1-bin spectra (in_last every beat), bin 7, data=1, eight consecutive cycles -> single out beat with out_data=8. Repeat with one idle cycle between beats -> same result.
- Extremes: navg_log2=15, 1-bin spectra, data=-8388608 for 32768 beats -> out_data=-274877906944.
- Reset mid-ACCUM (after 300 beats of spectrum 1), then rerun the scenario 2 stimulus -> identical results to scenario 2.
- Protocol: in_valid in IDLE, start during ACCUM, in_valid during FLUSH -> drop_err=1. The running sum is unaffected. drop_err clears on the next accepted start.
